interleaver_ctrl: RTL and testbench

Sequencing controller for the turbo-code interleaver datapath. Accepts one code block in natural order, writing it into the interleaver RAM. It then reads the block back in permuted order by stepping the pi1 permutation ROM and using its output as the RAM read address. It sits between the upstream bit source and the encoder's second constituent branch, and owns the address counter, phase FSM and ROM/RAM enables.

---
 rtl/interleaver_pkg.sv | 33 +++
 rtl/interleaver_rd_pipe.sv | 48 ++++
 rtl/interleaver_ctrl.sv | 144 ++++++++++++++
 tb/tb_interleaver_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interleaver_pkg.sv
// Shared definitions for the turbo-code interleaver sequencing controller.
// Latency: n/a (constants, types and a pure length-legality function).
// Backpressure: n/a.
//
// Contents:
//   ADDR_W     width of every block address / length
//   MAX_LEN    largest legal code block length
//   state_t    controller phase encoding (IDLE, FILL, DRAIN, DONE)
//   len_legal  block-length legality test
// Build option INTERLEAVER_CTRL_LENCHK_EN selects the full length check
// (40..MAX_LEN, multiple of 8); without it only K==0 is rejected.
package interleaver_pkg;

    localparam int ADDR_W  = 13;
    localparam int MAX_LEN = 6144;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // True when k may start a block.
    function automatic logic len_legal(input logic [ADDR_W-1:0] k);
`ifdef INTERLEAVER_CTRL_LENCHK_EN
        return (k >= ADDR_W'(40)) && (k <= ADDR_W'(MAX_LEN)) && (k[2:0] == 3'b000);
`else
        return (k != '0);
`endif
    endfunction

endpackage

// File: rtl/interleaver_rd_pipe.sv
// Read-side pipeline tracker: per-stage valid/last shift register behind the ROM and RAM.
// Latency: STAGES cycles from an issued index (S0) to out_valid (default 2: ROM then RAM).
// Backpressure: adv = ~out_valid | out_ready; the whole pipe freezes when the output is held.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s0_vld, s0_last     index being issued this cycle, and whether it is the block's final one
//   out_ready           downstream ready
//   adv                 pipeline advance; also the ROM/RAM read clock enable
//   s1_vld              ROM output holds a valid permuted index (RAM read address is live)
//   out_valid, out_last final stage: RAM read data valid, final bit of the block
module interleaver_rd_pipe #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s0_vld,
    input  logic s0_last,
    input  logic out_ready,
    output logic adv,
    output logic s1_vld,
    output logic out_valid,
    output logic out_last
);

    // Bit 0 tracks the ROM output register, bit STAGES-1 the RAM output register.
    logic [STAGES-1:0] vld_sr;
    logic [STAGES-1:0] last_sr;

    assign adv = ~vld_sr[STAGES-1] | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr  <= '0;
            last_sr <= '0;
        end else if (adv) begin
            // last is only ever carried alongside a valid entry, so out_last
            // can never be seen without out_valid.
            vld_sr  <= {vld_sr[STAGES-2:0], s0_vld};
            last_sr <= {last_sr[STAGES-2:0], s0_vld & s0_last};
        end
    end

    assign s1_vld    = vld_sr[0];
    assign out_valid = vld_sr[STAGES-1];
    assign out_last  = last_sr[STAGES-1];

endmodule

// File: rtl/interleaver_ctrl.sv
// Interleaver sequencer: writes a code block in natural order, then reads it back in pi1 order.
// Latency: last write -> DRAIN next cycle -> first out_valid 3 cycles after the last write; 1 bit/cycle.
// Backpressure: in_valid/in_ready on fill; out_ready low freezes ROM/RAM reads (rom_ce=0) and the pipe.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, blk_len        start pulse and block length K (sampled when accepted in IDLE)
//   in_valid, in_ready    upstream bit handshake (in_ready high only in FILL)
//   wr_en, wr_addr        RAM write strobe (in_valid & in_ready) and natural index
//   rom_addr, rom_ce      pi1 ROM index and ROM/RAM read-port clock enable
//   rom_q, rd_addr        ROM permuted index (1-cycle registered) and RAM read address
//   out_valid, out_ready  downstream handshake, RAM read data valid while out_valid
//   out_last              final permuted bit of the block
//   busy, err             not-IDLE indicator, sticky illegal-length flag
// Build option INTERLEAVER_CTRL_LENCHK_EN enables the full block-length check.
module interleaver_ctrl
    import interleaver_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] blk_len,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_ce,
    input  logic [ADDR_W-1:0] rom_q,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              err
);

    state_t            state;
    logic [ADDR_W-1:0] blk_k;      // latched block length K
    logic [ADDR_W-1:0] cnt;        // write index in FILL, ROM index in DRAIN
    logic              issue_done; // every ROM index of the block has been issued
    logic              err_q;

    logic adv;
    logic s0_vld;
    logic s1_vld;
    logic cnt_at_last;
    logic wr_accept;
    logic out_xfer_last;

    // cnt stops at K-1; issue_done marks that the final index has left S0, so
    // the counter never has to step past the last legal address.
    assign cnt_at_last   = (cnt == (blk_k - ADDR_W'(1)));
    assign wr_accept     = in_valid & in_ready;
    assign s0_vld        = (state == DRAIN) & ~issue_done;
    assign out_xfer_last = out_valid & out_ready & out_last;

    interleaver_rd_pipe #(
        .STAGES (2)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .s0_vld    (s0_vld),
        .s0_last   (cnt_at_last),
        .out_ready (out_ready),
        .adv       (adv),
        .s1_vld    (s1_vld),
        .out_valid (out_valid),
        .out_last  (out_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            blk_k      <= '0;
            cnt        <= '0;
            issue_done <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_legal(blk_len)) begin
                            blk_k      <= blk_len;
                            cnt        <= '0;
                            issue_done <= 1'b0;
                            err_q      <= 1'b0;
                            state      <= FILL;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end

                FILL: begin
                    if (wr_accept) begin
                        if (cnt_at_last) begin
                            cnt   <= '0;
                            state <= DRAIN;
                        end else begin
                            cnt <= cnt + ADDR_W'(1);
                        end
                    end
                end

                DRAIN: begin
                    if (adv && s0_vld) begin
                        if (cnt_at_last) begin
                            issue_done <= 1'b1;
                        end else begin
                            cnt <= cnt + ADDR_W'(1);
                        end
                    end
                    if (out_xfer_last) begin
                        state <= DONE;
                    end
                end

                DONE: begin
                    // Single busy cycle; any start seen here is dropped.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from registered state; only wr_en and rom_ce see the
    // live handshake inputs.
    assign in_ready = (state == FILL);
    assign wr_en    = wr_accept;
    assign wr_addr  = (state == FILL)  ? cnt : '0;
    assign rom_addr = (state == DRAIN) ? cnt : '0;
    assign rom_ce   = (state == DRAIN) & adv;
    // rom_q is only meaningful while S1 holds a valid index; elsewhere the
    // read address is parked at 0.
    assign rd_addr  = s1_vld ? rom_q : '0;
    assign busy     = (state != IDLE);
    assign err      = err_q;

endmodule

// File: tb/tb_interleaver_ctrl.sv
module tb_interleaver_ctrl;
    import interleaver_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] blk_len;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_ce;
    logic [ADDR_W-1:0] rom_q;
    logic [ADDR_W-1:0] rd_addr;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              err;

    int n_pass;
    int n_total;

    // Environment: pi1 ROM (registered) and interleaver RAM with 16-bit tags
    // per position so loss or duplication shows up as a data error.
    int          perm [0:8191];
    logic [15:0] src  [0:8191];
    logic [15:0] ram  [0:8191];
    logic [15:0] wr_dat;
    logic [15:0] ram_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    interleaver_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .blk_len   (blk_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rom_addr  (rom_addr),
        .rom_ce    (rom_ce),
        .rom_q     (rom_q),
        .rd_addr   (rd_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
    );

    always @(posedge clk) begin
        if (rom_ce) rom_q <= ADDR_W'(perm[rom_addr]);
    end

    always @(posedge clk) begin
        if (wr_en)  ram[wr_addr] <= wr_dat;
        if (rom_ce) ram_q <= ram[rd_addr];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  0);
        check({tag, "_wr_en"},     32'(wr_en),     0);
        check({tag, "_wr_addr"},   32'(wr_addr),   0);
        check({tag, "_rom_addr"},  32'(rom_addr),  0);
        check({tag, "_rom_ce"},    32'(rom_ce),    0);
        check({tag, "_rd_addr"},   32'(rd_addr),   0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_last"},  32'(out_last),  0);
        check({tag, "_busy"},      32'(busy),      0);
        check({tag, "_err"},       32'(err),       0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Pulse start for one cycle; returns #1 after the following falling edge.
    task automatic do_start(input int k);
        @(negedge clk);
        start   = 1'b1;
        blk_len = ADDR_W'(k);
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    // Runs one accepted block of length k through fill and drain, comparing
    // against a reference built from the rule "n-th output = data written at
    // natural index pi1[n]". abort_at>0 asserts reset after that many outputs.
    task automatic run_block(input int k, input int gap_pct, input int stall_pct,
                             input bit timing, input bit inject, input int abort_at);
        int written = 0, outs = 0, cyc = 0, budget;
        int first_wr = -1, last_wr = -1, first_ov = -1, last_out = -1;
        bit prev_stall = 0, done = 0;
        logic [ADDR_W-1:0] prev_rd = '0;
        logic [15:0] prev_q = '0;
        logic [15:0] exp_q[$];

        for (int i = 0; i < k; i++) begin
            perm[i] = i;
            src[i]  = 16'($urandom);
        end
        for (int i = k - 1; i > 0; i--) begin
            int j, t;
            j = $urandom_range(i, 0);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int n = 0; n < k; n++) exp_q.push_back(src[perm[n]]);

        budget = 6 * k + 200;
        while (!done && cyc < budget) begin
            @(negedge clk);
            if (written < k) in_valid = ($urandom_range(99) >= gap_pct);
            else             in_valid = ($urandom_range(1) == 1);
            wr_dat    = src[(written < k) ? written : 0];
            out_ready = ($urandom_range(99) >= stall_pct);
            start     = inject && ($urandom_range(7) == 0);
            blk_len   = ADDR_W'($urandom);
            #1;
            check("in_ready_phase", 32'(in_ready), 32'(written < k));
            if (inject) check("err_unaffected", 32'(err), 0);
            if (wr_en) begin
                check("wr_addr", 32'(wr_addr), written);
                if (written == 0) first_wr = cyc;
                if (written == k - 1) last_wr = cyc;
                written++;
            end
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (prev_stall) begin
                check("stall_out_valid", 32'(out_valid), 1);
                check("stall_rd_addr", 32'(rd_addr), 32'(prev_rd));
                check("stall_data", 32'(ram_q), 32'(prev_q));
            end
            if (out_valid && out_ready) begin
                if (outs < k) begin
                    check("out_data", 32'(ram_q), 32'(exp_q[outs]));
                    check("out_last", 32'(out_last), 32'(outs == k - 1));
                end else begin
                    check("out_overflow", outs, k - 1);
                end
                done = out_last;
                last_out = cyc;
                outs++;
                if (abort_at > 0 && outs == abort_at) begin
                    #2;
                    rst_n = 1'b0;
                    in_valid = 1'b0;
                    start = 1'b0;
                    #1;
                    check_reset_vals("midblk_rst");
                    @(negedge clk);
                    rst_n = 1'b1;
                    out_ready = 1'b1;
                    return;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_rd    = rd_addr;
            prev_q     = ram_q;
            cyc++;
        end

        check("block_complete", 32'(done), 1);
        check("wr_count", written, k);
        check("out_count", outs, k);
        if (timing) begin
            check("fill_throughput", last_wr - first_wr, k - 1);
            check("first_out_latency", first_ov - last_wr, 3);
            check("drain_throughput", last_out - first_ov, k - 1);
        end
        if (!done) begin
            apply_reset();
            return;
        end
        // DONE cycle (a start here must be ignored), then IDLE.
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        start = inject; blk_len = ADDR_W'(40);
        #1;
        check("done_busy", 32'(busy), 1);
        check("done_out_valid", 32'(out_valid), 0);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("idle_busy", 32'(busy), 0);
        @(negedge clk);
        #1;
        check("idle_stays_busy", 32'(busy), 0);
        check("idle_in_ready", 32'(in_ready), 0);
    endtask

    typedef struct {
        int len;
        bit exp_err;
        bit exp_acc;
    } vec_t;

    initial begin
        vec_t vecs[$];
        n_pass = 0; n_total = 0;
        rst_n = 1'b0; start = 1'b0; blk_len = '0;
        in_valid = 1'b0; out_ready = 1'b1; wr_dat = '0; rom_q = '0;

`ifdef INTERLEAVER_CTRL_LENCHK_EN
        vecs.push_back('{41,   1'b1, 1'b0});
        vecs.push_back('{40,   1'b0, 1'b1});
        vecs.push_back('{39,   1'b1, 1'b0});
        vecs.push_back('{6152, 1'b1, 1'b0});
        vecs.push_back('{0,    1'b1, 1'b0});
        vecs.push_back('{44,   1'b1, 1'b0});
        vecs.push_back('{48,   1'b0, 1'b1});
`else
        vecs.push_back('{0,  1'b1, 1'b0});
        vecs.push_back('{41, 1'b0, 1'b1});
        vecs.push_back('{0,  1'b1, 1'b0});
        vecs.push_back('{1,  1'b0, 1'b1});
        vecs.push_back('{3,  1'b0, 1'b1});
`endif

        repeat (3) @(negedge clk);
        #1;
        check_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;

        // K=40, continuous input, no stalls: exact latency and throughput.
        do_start(40);
        check("k40_in_ready", 32'(in_ready), 1);
        run_block(40, 0, 0, 1'b1, 1'b0, 0);

        // Start/legality table.
        foreach (vecs[i]) begin
            do_start(vecs[i].len);
            check($sformatf("tbl%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vecs[i].exp_acc));
            check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_acc));
            if (vecs[i].exp_acc) run_block(vecs[i].len, 10, 10, 1'b0, 1'b0, 0);
        end

        // Largest block with random gaps, stalls and stray start pulses.
        do_start(6144);
        run_block(6144, 30, 30, 1'b0, 1'b1, 0);

        // Random legal lengths.
        for (int b = 0; b < 3; b++) begin
            int k;
`ifdef INTERLEAVER_CTRL_LENCHK_EN
            k = 40 + 8 * $urandom_range(20);
`else
            k = $urandom_range(300, 1);
`endif
            do_start(k);
            run_block(k, 20, 40, 1'b0, 1'b1, 0);
        end

        // Reset at the 20th output of K=64, then a clean K=40 block.
        do_start(64);
        run_block(64, 0, 0, 1'b0, 1'b0, 20);
        @(negedge clk);
        #1;
        check_reset_vals("post_rst");
        do_start(40);
        run_block(40, 0, 0, 1'b1, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
